cache_arbiter: RTL
==================

# cache_arbiter

Two-requester arbiter that shares the single physical-memory port between the split L1 instruction cache and data cache. It sits between the two `cache_control4way`-based caches and physical memory (or L2). It serialises whole-line transactions: one cache owns the port from grant until `pmem_resp`. Ties are broken round-robin, and a conflict pulse feeds the performance counters.

## Interface
Parameters:
- none; widths come from `lc3b_types` (`lc3b_word` = 16 bits, `lc3b_block` = 128 bits).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `i_pmem_read`  in  1  I-cache line-read request.
- `i_pmem_address`  in  16  I-cache line address.
- `i_pmem_rdata`  out  128  line data to I-cache.
- `i_pmem_resp`  out  1  transaction complete, to I-cache.
- `d_pmem_read`  in  1  D-cache line-read request.
- `d_pmem_write`  in  1  D-cache line-writeback request.
- `d_pmem_address`  in  16  D-cache line address.
- `d_pmem_wdata`  in  128  D-cache writeback data.
- `d_pmem_rdata`  out  128  line data to D-cache.
- `d_pmem_resp`  out  1  transaction complete, to D-cache.
- `pmem_read`  out  1  read strobe to memory.
- `pmem_write`  out  1  write strobe to memory.
- `pmem_address`  out  16  address to memory.
- `pmem_wdata`  out  128  write data to memory.
- `pmem_rdata`  in  128  read data from memory.
- `pmem_resp`  in  1  memory completion.
- `arb_conflict_inc`  out  1  one-cycle pulse when both caches request in the same IDLE cycle.

## Operation
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- Reset values: state = IDLE, `last_grant` = I. All strobe, resp and pulse outputs are 0; `pmem_address` and `pmem_wdata` are 0.
- IDLE transitions:
  - only I requesting → GRANT_I.
  - only D requesting (read or write) → GRANT_D.
  - both requesting → grant the side not equal to `last_grant`, and assert `arb_conflict_inc`.
  - neither requesting → stay in IDLE.
- GRANT_I:
  - `pmem_read` = `i_pmem_read`; `pmem_write` = 0; `pmem_address` = `i_pmem_address`.
  - `i_pmem_resp` = `pmem_resp`.
  - On `pmem_resp`: set `last_grant` = I, go to RELEASE.
- GRANT_D:
  - `pmem_read`/`pmem_write` and `pmem_address` come from the `d_*` inputs; `pmem_wdata` = `d_pmem_wdata`.
  - `d_pmem_resp` = `pmem_resp`.
  - On `pmem_resp`: set `last_grant` = D, go to RELEASE.
- RELEASE:
  - All memory strobes are 0 for exactly one cycle, so memory sees the strobe drop (matches the caches' stall/update_cache cycle). Then → IDLE.
  - A request still high here is ignored.
- Data and resp routing:
  - `i_pmem_rdata` and `d_pmem_rdata` are both wired to `pmem_rdata` unconditionally.
  - The resp of the non-granted side is always 0.
- Illegal input, not checked: a requester dropping its request before resp. The grant is held until `pmem_resp` regardless; strobes follow the live request inputs.
- A D-cache writeback followed by a refill is two separate transactions. The I-cache may win the port in between. This is legal; the D-cache just waits.

## Timing
- Grant latency: request high in IDLE at cycle N → strobe on `pmem_*` at N+1.
- Response path is combinational, zero added latency: `pmem_resp` → granted `*_pmem_resp` in the same cycle.
- Back-to-back: a transaction occupies grant cycles plus 1 RELEASE plus 1 IDLE. The minimum gap between consecutive memory transactions is 2 cycles.
- `reset` asserted mid-transaction:
  - immediate return to IDLE; strobes drop asynchronously; `last_grant` = I.
  - Memory must tolerate the abandoned access.
- `pmem_resp` arriving in IDLE or RELEASE is ignored and not forwarded.
- `arb_conflict_inc` is high for exactly the one IDLE cycle in which the tie is resolved.

## Structure
- The `arb_state_t` enum (IDLE, GRANT_I, GRANT_D, RELEASE) and the `arb_req_t` encoding (I = 0, D = 1) belong in `lc3b_types`.
- `lc3b_word` and `lc3b_block` are reused from `lc3b_types`.
- No sub-module: the block is a single FSM plus an output mux.
- Split into three processes: state register with async reset, next-state logic, and output mux.

## Test plan
- I-only read of 0x1230; memory resp after 5 cycles:
  - `pmem_read` = 1 and `pmem_address` = 0x1230 from cycle 1.
  - `i_pmem_resp` pulses once; `d_pmem_resp` stays 0.
  - `pmem_read` = 0 in RELEASE.
- Simultaneous I read 0x0040 and D write 0x8000 right after reset:
  - D granted first (`last_grant` = I); `arb_conflict_inc` = 1 for one cycle.
  - `pmem_wdata` = `d_pmem_wdata` during GRANT_D.
  - I granted after RELEASE/IDLE.
- Both caches request continuously for 4 transactions: grants alternate D, I, D, I; `arb_conflict_inc` counts 4.
- D writeback then refill, with I requesting between them: order D-write, I-read, D-read; each resp reaches only its requester.
- `reset` asserted while in GRANT_D with `pmem_write` high:
  - `pmem_write` drops without waiting for a clock edge; state = IDLE.
  - Next tie grants D.
- Spurious `pmem_resp` in IDLE: no resp output asserted, no state change.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b widths plus the cache arbiter's state and requester encodings.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_REQ_I = 1'b0,
        ARB_REQ_D = 1'b1
    } arb_req_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the L1 I-cache and D-cache,
// one whole-line transaction at a time, ties broken round-robin.
module cache_arbiter
    import lc3b_types::*;
(
    input  logic      clk,
    input  logic      reset,

    input  logic      i_pmem_read,
    input  lc3b_word  i_pmem_address,
    output lc3b_block i_pmem_rdata,
    output logic      i_pmem_resp,

    input  logic      d_pmem_read,
    input  logic      d_pmem_write,
    input  lc3b_word  d_pmem_address,
    input  lc3b_block d_pmem_wdata,
    output lc3b_block d_pmem_rdata,
    output logic      d_pmem_resp,

    output logic      pmem_read,
    output logic      pmem_write,
    output lc3b_word  pmem_address,
    output lc3b_block pmem_wdata,
    input  lc3b_block pmem_rdata,
    input  logic      pmem_resp,

    output logic      arb_conflict_inc
);

    arb_state_t state_q, state_d;
    arb_req_t   last_q, last_d;
    logic       i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= ARB_REQ_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req)
                    state_d = (last_q == ARB_REQ_I) ? GRANT_D : GRANT_I;
                else if (i_req)
                    state_d = GRANT_I;
                else if (d_req)
                    state_d = GRANT_D;
            end
            GRANT_I: begin
                if (pmem_resp) begin
                    last_d  = ARB_REQ_I;
                    state_d = RELEASE;
                end
            end
            GRANT_D: begin
                if (pmem_resp) begin
                    last_d  = ARB_REQ_D;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes follow the live request lines of whichever side holds the grant.
    always_comb begin
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = '0;
        pmem_wdata       = '0;
        i_pmem_resp      = 1'b0;
        d_pmem_resp      = 1'b0;
        arb_conflict_inc = 1'b0;
        unique case (state_q)
            IDLE: arb_conflict_inc = i_req & d_req & ~reset;
            GRANT_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            GRANT_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule
